led_chase_arena: RTL and testbench
==================================

// Module: led_chase_arena
// PURPOSE
//  Parametrised LED animation engine for the board LED bar: a solid block bounces between two
//  centre limits while two single-dot chasers bounce between the bar ends and the block edges.
//  Single clock domain: internal tick enables replace derived clocks. Adds single-step debug
//  advance and a saturating bounce counter. Top level drives the LED pins from it.
// PARAMETERS
//  N_LED      16  LED bar width
//  BLK_HALF   1   block half-width; block spans c-BLK_HALF..c+BLK_HALF
//  BLK_MIN    5   lowest block centre
//  BLK_MAX    10  highest block centre
//  FAST_LOG2  23  fast tick period = 2**FAST_LOG2 clk
//  SLOW_LOG2  25  slow tick period = 2**SLOW_LOG2 clk; must be > FAST_LOG2
//  CNT_W      8   bounce counter width
//  Legal only if BLK_MIN-BLK_HALF-1 >= 1 and BLK_MAX+BLK_HALF+1 <= N_LED-2 (elaboration check).
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous, active-high reset
//  en         in   1          1: run on ticks; 0: frozen except step
//  speed      in   1          0: chasers slow / block fast; 1: chasers fast / block slow
//  step       in   1          synchronous; rising edge advances all objects once when en=0
//  led        out  N_LED      OR of left dot, right dot and block mask
//  blk_pos    out  clog2(N)   current block centre c
//  bounce_cnt out  CNT_W      saturating count of chaser-block bounces
// BEHAVIOUR
//  Reset (async, immediate): prescaler=0; c=BLK_MAX, blk dir=DN; L=N_LED-1, dir=DN; R=0, dir=UP;
//   bounce_cnt=0; step edge-detect register=0. Default reset led = 16'h8E01.
//  Prescaler: free-running SLOW_LOG2-bit counter, counts every clk regardless of en.
//   fast_tick = low FAST_LOG2 bits == all-ones; slow_tick = whole counter == all-ones.
//   Each tick is a 1-clk pulse; slow_tick always coincides with a fast_tick.
//  adv_blk/adv_ch = en ? (selected tick) : step_rise; step ignored while en=1.
//  Block, on adv_blk: c>=BLK_MAX -> dir=DN, c-1; c<=BLK_MIN -> dir=UP, c+1; else move by dir.
//  Left chaser L, on adv_ch: L <= c+BLK_HALF+1 -> dir=UP, L+1, bounce event;
//   elif L==N_LED-1 -> dir=DN, L-1; else move by dir.
//  Right chaser R, on adv_ch: R+BLK_HALF+1 >= c -> dir=DN, R-1, bounce event;
//   elif R==0 -> dir=UP, R+1; else move by dir.
//  Compares use the pre-update (registered) c, L and R. Arithmetic is widened one bit, with no
//   unsigned wrap. Simultaneous block and chaser advances both use old values. A transient
//   dot/block overlap is permitted; led simply ORs.
//  bounce_cnt: +1 per event, +2 if L and R bounce in the same cycle; saturates at 2**CNT_W-1;
//   cleared only by rst.
//  led, blk_pos: combinational from state registers. They change one clk after the advancing edge.
//  Step held high for many cycles advances once only (rising edge).
// STRUCTURE
//  led_arena_pkg: DIR_DN=0/DIR_UP=1 constants; onehot(idx) and block_mask(c) functions.
//  Sub-module led_tick_gen (prescaler -> fast_tick, slow_tick). Top holds three position/direction
//   FSMs, step edge detect, counter and led OR.
// TESTING (sim params FAST_LOG2=2, SLOW_LOG2=4, defaults otherwise)
//  rst pulse -> led=16'h8E01, blk_pos=10, bounce_cnt=0.
//  en=0, one step pulse -> led=16'h4702 (L=14, c=9, R=1); step held 20 clk -> one advance.
//  en=0, 5 step pulses -> R=3, c=5, L=10, bounce_cnt=1, led=16'h0478.
//  en=1, speed=0 -> c changes every 4 clk, L/R every 16; speed=1 -> swapped; en=0 -> frozen 1000 clk.
//  rst asserted between clk edges mid-run -> led=16'h8E01 before next clk edge; counter 0.
//  CNT_W=2, long free run -> bounce_cnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/led_arena_pkg.sv
// led_arena_pkg: shared direction type and LED mask helpers.
// Masks are built MASK_W wide; callers size-cast to their bar width.
package led_arena_pkg;

    localparam int MASK_W = 64;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    function automatic logic [MASK_W-1:0] onehot(
        input int unsigned idx
    );
        return MASK_W'(1) << idx;
    endfunction

    // Solid run of 2*half+1 ones centred on c (c >= half assumed).
    function automatic logic [MASK_W-1:0] block_mask(
        input int unsigned c,
        input int unsigned half
    );
        logic [MASK_W-1:0] run;
        run = (MASK_W'(1) << (2 * half + 1)) - MASK_W'(1);
        return run << (c - half);
    endfunction

endpackage

// File: rtl/led_chase_arena_tick.sv
// led_tick_gen: free-running prescaler producing 1-clk fast/slow enables.
// slow_tick is a subset of fast_tick because both test all-ones low bits.
module led_tick_gen
    import led_arena_pkg::*;
#(
    parameter int FAST_LOG2 = 23,
    parameter int SLOW_LOG2 = 25
) (
    input  logic clk,
    input  logic rst,
    output logic fast_tick,
    output logic slow_tick
);

    logic [SLOW_LOG2-1:0] pre;

    // prescaler counts every clk, independent of run/freeze state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else begin
            pre <= pre + SLOW_LOG2'(1);
        end
    end

    assign fast_tick = &pre[FAST_LOG2-1:0];
    assign slow_tick = &pre;

endmodule

// File: rtl/led_chase_arena.sv
// led_chase_arena: bouncing centre block plus two chaser dots on an LED bar.
// Positions compare in one extra bit so edge arithmetic never wraps.
module led_chase_arena
    import led_arena_pkg::*;
#(
    parameter int N_LED     = 16,
    parameter int BLK_HALF  = 1,
    parameter int BLK_MIN   = 5,
    parameter int BLK_MAX   = 10,
    parameter int FAST_LOG2 = 23,
    parameter int SLOW_LOG2 = 25,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     speed,
    input  logic                     step,
    output logic [N_LED-1:0]         led,
    output logic [$clog2(N_LED)-1:0] blk_pos,
    output logic [CNT_W-1:0]         bounce_cnt
);

    localparam int PW = $clog2(N_LED);

    typedef logic [PW:0] wide_t;

    localparam wide_t ONE   = wide_t'(1);
    localparam wide_t SPAN  = wide_t'(BLK_HALF + 1);
    localparam wide_t TOP   = wide_t'(N_LED - 1);
    localparam wide_t C_MIN = wide_t'(BLK_MIN);
    localparam wide_t C_MAX = wide_t'(BLK_MAX);

    if (!((BLK_MIN - BLK_HALF - 1 >= 1)
          && (BLK_MAX + BLK_HALF + 1 <= N_LED - 2)
          && (BLK_MIN < BLK_MAX)
          && (N_LED <= MASK_W)
          && (FAST_LOG2 >= 1)
          && (SLOW_LOG2 > FAST_LOG2)
          && (CNT_W >= 1))) begin : g_bad_cfg
        $error("led_chase_arena: illegal parameter set");
    end

    logic          fast_tick;
    logic          slow_tick;
    logic          step_q;
    logic          step_rise;
    logic          adv_blk;
    logic          adv_ch;
    logic [PW-1:0] c_q;
    logic [PW-1:0] l_q;
    logic [PW-1:0] r_q;
    dir_t          c_dir;
    dir_t          l_dir;
    dir_t          r_dir;
    wide_t         c_w;
    wide_t         l_w;
    wide_t         r_w;
    logic          c_at_max;
    logic          c_at_min;
    logic          l_hit;
    logic          l_end;
    logic          r_hit;
    logic          r_end;
    logic          l_bounce;
    logic          r_bounce;
    logic [CNT_W:0] cnt_sum;
    logic [CNT_W-1:0] cnt_q;

    led_tick_gen #(
        .FAST_LOG2 (FAST_LOG2),
        .SLOW_LOG2 (SLOW_LOG2)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .fast_tick (fast_tick),
        .slow_tick (slow_tick)
    );

    assign step_rise = step & ~step_q;

    // speed picks which object rides the fast tick; step only when frozen
    assign adv_blk = en ? (speed ? slow_tick : fast_tick) : step_rise;
    assign adv_ch  = en ? (speed ? fast_tick : slow_tick) : step_rise;

    assign c_w = {1'b0, c_q};
    assign l_w = {1'b0, l_q};
    assign r_w = {1'b0, r_q};

    assign c_at_max = (c_w >= C_MAX);
    assign c_at_min = (c_w <= C_MIN);
    assign l_hit    = (l_w <= c_w + SPAN);
    assign l_end    = (l_w == TOP);
    assign r_hit    = (r_w + SPAN >= c_w);
    assign r_end    = (r_w == '0);

    assign l_bounce = adv_ch & l_hit;
    assign r_bounce = adv_ch & r_hit;

    // step edge detector; runs regardless of en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // block centre bounces between its two centre limits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q   <= PW'(BLK_MAX);
            c_dir <= DIR_DN;
        end else if (adv_blk) begin
            unique case (1'b1)
                c_at_max: begin
                    c_dir <= DIR_DN;
                    c_q   <= PW'(c_w - ONE);
                end
                c_at_min: begin
                    c_dir <= DIR_UP;
                    c_q   <= PW'(c_w + ONE);
                end
                default: begin
                    c_q <= (c_dir == DIR_UP)
                         ? PW'(c_w + ONE)
                         : PW'(c_w - ONE);
                end
            endcase
        end
    end

    // left chaser bounces between the top bar end and the block's upper edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q   <= PW'(N_LED - 1);
            l_dir <= DIR_DN;
        end else if (adv_ch) begin
            unique case (1'b1)
                l_hit: begin
                    l_dir <= DIR_UP;
                    l_q   <= PW'(l_w + ONE);
                end
                l_end: begin
                    l_dir <= DIR_DN;
                    l_q   <= PW'(l_w - ONE);
                end
                default: begin
                    l_q <= (l_dir == DIR_UP)
                         ? PW'(l_w + ONE)
                         : PW'(l_w - ONE);
                end
            endcase
        end
    end

    // right chaser bounces between bit 0 and the block's lower edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_dir <= DIR_UP;
        end else if (adv_ch) begin
            unique case (1'b1)
                r_hit: begin
                    r_dir <= DIR_DN;
                    r_q   <= PW'(r_w - ONE);
                end
                r_end: begin
                    r_dir <= DIR_UP;
                    r_q   <= PW'(r_w + ONE);
                end
                default: begin
                    r_q <= (r_dir == DIR_UP)
                         ? PW'(r_w + ONE)
                         : PW'(r_w - ONE);
                end
            endcase
        end
    end

    assign cnt_sum = {1'b0, cnt_q}
                   + (CNT_W + 1)'(l_bounce)
                   + (CNT_W + 1)'(r_bounce);

    // saturating bounce counter; a carry into the top bit means overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_sum[CNT_W]) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_sum[CNT_W-1:0];
        end
    end

    assign led = N_LED'(onehot(32'(l_q))
                      | onehot(32'(r_q))
                      | block_mask(32'(c_q), BLK_HALF));

    assign blk_pos    = c_q;
    assign bounce_cnt = cnt_q;

endmodule

// File: tb/tb_led_chase_arena.sv
// tb_led_chase_arena: scoreboard bench for the LED arena.
// A behavioural model pushes expected outputs each cycle; tasks pop and compare.
module tb_led_chase_arena;

    localparam int BH   = 1;
    localparam int BMIN = 5;
    localparam int BMAX = 10;

    typedef struct packed {
        logic [15:0] led;
        logic [3:0]  pos;
        logic [7:0]  cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        speed;
    logic        step;
    logic [15:0] led;
    logic [3:0]  blk_pos;
    logic [7:0]  bounce_cnt;
    logic [15:0] led2;
    logic [3:0]  blk_pos2;
    logic [1:0]  cnt2;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    int m_pre, m_c, m_l, m_r, m_cnt, m_cnt2;
    bit m_cd, m_ld, m_rd, m_sq;

    led_chase_arena #(
        .N_LED(16), .BLK_HALF(1), .BLK_MIN(5), .BLK_MAX(10),
        .FAST_LOG2(2), .SLOW_LOG2(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .speed(speed), .step(step),
        .led(led), .blk_pos(blk_pos), .bounce_cnt(bounce_cnt)
    );

    led_chase_arena #(
        .N_LED(16), .BLK_HALF(1), .BLK_MIN(5), .BLK_MAX(10),
        .FAST_LOG2(2), .SLOW_LOG2(4), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .en(en), .speed(speed), .step(step),
        .led(led2), .blk_pos(blk_pos2), .bounce_cnt(cnt2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pre = 0; m_sq = 0;
        m_c = BMAX; m_cd = 0;
        m_l = 15; m_ld = 0;
        m_r = 0; m_rd = 1;
        m_cnt = 0; m_cnt2 = 0;
    endtask

    function automatic logic [15:0] model_led();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++)
            if (i == m_l || i == m_r || (i >= m_c - BH && i <= m_c + BH))
                v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.led  = model_led();
        e.pos  = 4'(m_c);
        e.cnt  = 8'(m_cnt);
        e.cnt2 = 2'(m_cnt2);
        sb.push_back(e);
    endtask

    task automatic model_edge(input bit e, input bit sp, input bit st);
        bit ft, stk, rise, ab, ac;
        int nc, nl, nr, bn;
        ft   = (m_pre % 4) == 3;
        stk  = (m_pre == 15);
        rise = st && !m_sq;
        ab   = e ? (sp ? stk : ft) : rise;
        ac   = e ? (sp ? ft : stk) : rise;
        nc = m_c; nl = m_l; nr = m_r; bn = 0;
        if (ab) begin
            if (m_c >= BMAX) begin m_cd = 0; nc = m_c - 1; end
            else if (m_c <= BMIN) begin m_cd = 1; nc = m_c + 1; end
            else nc = m_cd ? m_c + 1 : m_c - 1;
        end
        if (ac) begin
            if (m_l <= m_c + BH + 1) begin m_ld = 1; nl = m_l + 1; bn++; end
            else if (m_l == 15) begin m_ld = 0; nl = m_l - 1; end
            else nl = m_ld ? m_l + 1 : m_l - 1;
            if (m_r + BH + 1 >= m_c) begin m_rd = 0; nr = m_r - 1; bn++; end
            else if (m_r == 0) begin m_rd = 1; nr = m_r + 1; end
            else nr = m_rd ? m_r + 1 : m_r - 1;
        end
        m_c = nc; m_l = nl; m_r = nr;
        m_cnt  = (m_cnt + bn > 255) ? 255 : m_cnt + bn;
        m_cnt2 = (m_cnt2 + bn > 3) ? 3 : m_cnt2 + bn;
        m_sq  = st;
        m_pre = (m_pre + 1) % 16;
    endtask

    task automatic run_cycle(input bit e, input bit sp, input bit st);
        @(negedge clk);
        rst = 1'b0; en = e; speed = sp; step = st;
        model_edge(e, sp, st);
        push_exp();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; step = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 1'b0; speed = 1'b0; step = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_exp();
        e = sb.pop_front();
        n_chk++;
        if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
            !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
            $display("FAIL reset_sb: got %h want %h",
                {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
        else n_pass++;
        n_chk++;
        if ({led, blk_pos, bounce_cnt} !== {16'h8E01, 4'd10, 8'd0})
            $display("FAIL reset_const: got led=%h pos=%0d cnt=%0d want 8e01/10/0",
                led, blk_pos, bounce_cnt);
        else n_pass++;
    endtask

    task automatic test_single_step();
        exp_t e;
        int moves;
        logic [3:0] prev;
        run_cycle(0, 0, 1);
        e = sb.pop_front();
        n_chk++;
        if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
            !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
            $display("FAIL step_once: got %h want %h",
                {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
        else n_pass++;
        n_chk++;
        if ({led, blk_pos} !== {16'h4702, 4'd9})
            $display("FAIL step_once_const: got led=%h pos=%0d want 4702/9", led, blk_pos);
        else n_pass++;
        moves = 0;
        prev = blk_pos;
        for (int i = 0; i < 20; i++) begin
            run_cycle(0, 0, 1);
            e = sb.pop_front();
            n_chk++;
            if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
                !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
                $display("FAIL step_hold: cyc %0d got %h want %h", i,
                    {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                    {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
            else n_pass++;
            if (blk_pos != prev) moves++;
            prev = blk_pos;
        end
        n_chk++;
        if (moves != 0 || led !== 16'h4702)
            $display("FAIL step_hold_const: moves=%0d led=%h want 0/4702", moves, led);
        else n_pass++;
        run_cycle(0, 0, 0);
        void'(sb.pop_front());
    endtask

    task automatic test_multi_step();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            run_cycle(0, 0, (i % 2) == 0);
            e = sb.pop_front();
            n_chk++;
            if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
                !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
                $display("FAIL multi_step: cyc %0d got %h want %h", i,
                    {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                    {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
            else n_pass++;
        end
        n_chk++;
        if ({led, blk_pos, bounce_cnt} !== {16'h0478, 4'd5, 8'd1})
            $display("FAIL multi_step_const: got led=%h pos=%0d cnt=%0d want 0478/5/1",
                led, blk_pos, bounce_cnt);
        else n_pass++;
    endtask

    task automatic test_free_run();
        exp_t e;
        int moves;
        logic [3:0] prev;
        apply_reset();
        for (int sp = 0; sp < 2; sp++) begin
            moves = 0;
            prev = blk_pos;
            for (int i = 0; i < 64; i++) begin
                run_cycle(1, sp[0], 1'($urandom_range(0, 1)));
                e = sb.pop_front();
                n_chk++;
                if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
                    !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
                    $display("FAIL free_run: sp %0d cyc %0d got %h want %h", sp, i,
                        {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                        {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
                else n_pass++;
                if (blk_pos != prev) moves++;
                prev = blk_pos;
            end
            n_chk++;
            if (moves != (sp == 0 ? 16 : 4))
                $display("FAIL free_run_rate: sp %0d block moves=%0d want %0d",
                    sp, moves, (sp == 0 ? 16 : 4));
            else n_pass++;
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        logic [15:0] led0;
        logic [3:0]  pos0;
        led0 = led;
        pos0 = blk_pos;
        for (int i = 0; i < 1000; i++) begin
            run_cycle(0, 1'($urandom_range(0, 1)), 0);
            e = sb.pop_front();
            n_chk++;
            if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
                !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
                $display("FAIL freeze: cyc %0d got %h want %h", i,
                    {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                    {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
            else n_pass++;
        end
        n_chk++;
        if ({led, blk_pos} !== {led0, pos0})
            $display("FAIL freeze_const: got %h/%0d want %h/%0d", led, blk_pos, led0, pos0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 37; i++) begin
            run_cycle(1, 1, 0);
            void'(sb.pop_front());
        end
        #2;
        rst = 1'b1;
        model_reset();
        push_exp();
        #1;
        e = sb.pop_front();
        n_chk++;
        if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
            !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
            $display("FAIL async_reset: got %h want %h",
                {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
        else n_pass++;
        n_chk++;
        if ({led, bounce_cnt} !== {16'h8E01, 8'd0})
            $display("FAIL async_reset_const: got led=%h cnt=%0d want 8e01/0", led, bounce_cnt);
        else n_pass++;
        run_cycle(1, 0, 0);
        e = sb.pop_front();
        n_chk++;
        if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
            !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
            $display("FAIL async_release: got %h want %h",
                {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
        else n_pass++;
    endtask

    task automatic test_saturation();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            run_cycle(1, 1, 0);
            e = sb.pop_front();
            n_chk++;
            if ({led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2}
                !== {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2})
                $display("FAIL saturate: cyc %0d got %h want %h", i,
                    {led, blk_pos, bounce_cnt, led2, blk_pos2, cnt2},
                    {e.led, e.pos, e.cnt, e.led, e.pos, e.cnt2});
            else n_pass++;
        end
        n_chk++;
        if (cnt2 !== 2'd3 || bounce_cnt < 8'd4)
            $display("FAIL saturate_const: cnt2=%0d cnt=%0d want 3 and >=4", cnt2, bounce_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_multi_step();
        test_free_run();
        test_freeze();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
